// File: rtl/bp_cce_mock_mem.sv
// bp_cce_mock_mem: behavioural CCE-side memory responder.
// One outstanding transaction, programmable response latency.
module bp_cce_mock_mem #(
    parameter int num_lce_p             = 2,
    parameter int lce_assoc_p           = 8,
    parameter int paddr_width_p         = 32,
    parameter int block_size_in_bytes_p = 64,
    parameter int num_blocks_p          = 1024,
    parameter int mem_latency_p         = 4,
    localparam int block_size_in_bits_lp     = block_size_in_bytes_p * 8,
    localparam int lg_block_size_in_bytes_lp = $clog2(block_size_in_bytes_p),
    localparam int lg_num_blocks_lp  = (num_blocks_p > 1) ? $clog2(num_blocks_p) : 1,
    localparam int lce_id_width_lp   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
    localparam int way_id_width_lp   = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
    localparam int msg_type_width_lp = 2,
    localparam int hdr_width_lp      = msg_type_width_lp + 2 * paddr_width_p
                                     + lce_id_width_lp + way_id_width_lp + 1,
    localparam int cce_mem_cmd_width_lp       = hdr_width_lp,
    localparam int cce_mem_data_cmd_width_lp  = hdr_width_lp + block_size_in_bits_lp,
    localparam int mem_cce_resp_width_lp      = hdr_width_lp,
    localparam int mem_cce_data_resp_width_lp = hdr_width_lp + block_size_in_bits_lp
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [cce_mem_cmd_width_lp-1:0]       mem_cmd_i,
    input  logic                                  mem_cmd_v_i,
    output logic                                  mem_cmd_ready_o,
    input  logic [cce_mem_data_cmd_width_lp-1:0]  mem_data_cmd_i,
    input  logic                                  mem_data_cmd_v_i,
    output logic                                  mem_data_cmd_ready_o,
    output logic [mem_cce_resp_width_lp-1:0]      mem_resp_o,
    output logic                                  mem_resp_v_o,
    input  logic                                  mem_resp_yumi_i,
    output logic [mem_cce_data_resp_width_lp-1:0] mem_data_resp_o,
    output logic                                  mem_data_resp_v_o,
    input  logic                                  mem_data_resp_yumi_i
);

    // Header sits in the MSBs of every message; block data fills the LSBs.
    typedef struct packed {
        logic [msg_type_width_lp-1:0] msg_type;
        logic [paddr_width_p-1:0]     addr;
        logic [lce_id_width_lp-1:0]   lce_id;
        logic [way_id_width_lp-1:0]   way_id;
        logic [paddr_width_p-1:0]     req_addr;
        logic                         non_cacheable;
    } hdr_s;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [7:0] lat_lp = 8'(mem_latency_p);

    logic [1:0] state_r;
    logic [7:0] cnt_r;
    logic       kind_wr_r;
    hdr_s       hdr_r;

    logic [block_size_in_bits_lp-1:0] mem_r [num_blocks_p];

    hdr_s                             cmd_hdr;
    hdr_s                             dc_hdr;
    logic [block_size_in_bits_lp-1:0] dc_data;
    logic [lg_num_blocks_lp-1:0]      wr_idx;
    logic [lg_num_blocks_lp-1:0]      rd_idx;
    logic                             idle;
    logic                             resp;

    assign cmd_hdr = mem_cmd_i;
    assign dc_hdr  = mem_data_cmd_i[cce_mem_data_cmd_width_lp-1 -: hdr_width_lp];
    assign dc_data = mem_data_cmd_i[block_size_in_bits_lp-1:0];
    assign wr_idx  = dc_hdr.addr[lg_block_size_in_bytes_lp +: lg_num_blocks_lp];
    assign rd_idx  = hdr_r.addr[lg_block_size_in_bytes_lp +: lg_num_blocks_lp];

    // Outputs are gated by reset so nothing leaks while reset is held.
    assign idle = reset_n_i & (state_r == IDLE);
    assign resp = reset_n_i & (state_r == RESP);

    assign mem_data_cmd_ready_o = idle;
    assign mem_cmd_ready_o      = idle & ~mem_data_cmd_v_i;
    assign mem_resp_v_o         = resp & kind_wr_r;
    assign mem_data_resp_v_o    = resp & ~kind_wr_r;
    assign mem_resp_o           = mem_resp_v_o ? hdr_r : '0;
    assign mem_data_resp_o      = mem_data_resp_v_o ? {hdr_r, mem_r[rd_idx]} : '0;

    // Transaction FSM, header latch and block array.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            kind_wr_r <= 1'b0;
            hdr_r     <= '0;
            for (int i = 0; i < num_blocks_p; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            unique case (state_r)
                IDLE: begin
                    if (mem_data_cmd_v_i || mem_cmd_v_i) begin
                        cnt_r   <= lat_lp;
                        state_r <= (lat_lp == 8'd0) ? RESP : WAIT;
                    end
                    if (mem_data_cmd_v_i) begin
                        mem_r[wr_idx] <= dc_data;
                        hdr_r         <= dc_hdr;
                        kind_wr_r     <= 1'b1;
                    end else if (mem_cmd_v_i) begin
                        hdr_r     <= cmd_hdr;
                        kind_wr_r <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 8'd1;
                    if (cnt_r <= 8'd1) begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    if (kind_wr_r ? mem_resp_yumi_i : mem_data_resp_yumi_i) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // A consumer must never take a response that is not being offered.
    a_resp_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_resp_yumi_i |-> mem_resp_v_o);
    a_data_resp_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_data_resp_yumi_i |-> mem_data_resp_v_o);

endmodule

// File: tb/tb_bp_cce_mock_mem.sv
// tb_bp_cce_mock_mem: scoreboard bench for bp_cce_mock_mem.
// 64 B blocks, 16 blocks, latency 4.
module tb_bp_cce_mock_mem;

    localparam int LAT  = 4;
    localparam int HW   = 71;
    localparam int BW   = 512;
    localparam int DCW  = HW + BW;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [HW-1:0]  mem_cmd = '0;
    logic           mem_cmd_v = 1'b0;
    logic           mem_cmd_ready;
    logic [DCW-1:0] mem_data_cmd = '0;
    logic           mem_data_cmd_v = 1'b0;
    logic           mem_data_cmd_ready;
    logic [HW-1:0]  mem_resp;
    logic           mem_resp_v;
    logic           mem_resp_yumi = 1'b0;
    logic [DCW-1:0] mem_data_resp;
    logic           mem_data_resp_v;
    logic           mem_data_resp_yumi = 1'b0;

    bp_cce_mock_mem #(
        .num_lce_p(2),
        .lce_assoc_p(8),
        .paddr_width_p(32),
        .block_size_in_bytes_p(64),
        .num_blocks_p(16),
        .mem_latency_p(LAT)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .mem_cmd_i(mem_cmd),
        .mem_cmd_v_i(mem_cmd_v),
        .mem_cmd_ready_o(mem_cmd_ready),
        .mem_data_cmd_i(mem_data_cmd),
        .mem_data_cmd_v_i(mem_data_cmd_v),
        .mem_data_cmd_ready_o(mem_data_cmd_ready),
        .mem_resp_o(mem_resp),
        .mem_resp_v_o(mem_resp_v),
        .mem_resp_yumi_i(mem_resp_yumi),
        .mem_data_resp_o(mem_data_resp),
        .mem_data_resp_v_o(mem_data_resp_v),
        .mem_data_resp_yumi_i(mem_data_resp_yumi)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [639:0] pay;
    } exp_t;

    exp_t          sbq[$];
    logic [BW-1:0] model [16];
    int            n_chk = 0;
    int            n_fail = 0;
    bit            watch = 1'b0;
    int            pulses = 0;

    always @(negedge clk) begin
        if (watch && mem_data_resp_v) pulses++;
    end

    task automatic chk(input string tag, input logic [639:0] got,
                       input logic [639:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic [1:0] t,
        input logic [31:0] a, input logic l, input logic [2:0] w,
        input logic nc);
        return {t, a, l, w, a, nc};
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:6]);
    endfunction

    task automatic set_wr(input logic [31:0] a, input logic [BW-1:0] d,
                          input logic l, input logic [2:0] w);
        mem_data_cmd   = {mk_hdr(2'd1, a, l, w, 1'b0), d};
        mem_data_cmd_v = 1'b1;
    endtask

    task automatic set_rd(input logic [31:0] a, input logic l,
                          input logic [2:0] w, input logic nc);
        mem_cmd   = mk_hdr(2'd0, a, l, w, nc);
        mem_cmd_v = 1'b1;
    endtask

    // Wait for the channel's ready, then record what the DUT must return.
    task automatic acc(input bit wr);
        exp_t        e;
        int          n = 0;
        logic [31:0] a;
        while (!(wr ? mem_data_cmd_ready : mem_cmd_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(wr ? "accept_wr_ready" : "accept_rd_ready",
            wr ? mem_data_cmd_ready : mem_cmd_ready, 1);
        e.wr = wr;
        if (wr) begin
            a = mem_data_cmd[DCW-3 -: 32];
            model[idx(a)] = mem_data_cmd[BW-1:0];
            e.pay = 640'(mem_data_cmd[DCW-1 -: HW]);
        end else begin
            a = mem_cmd[HW-3 -: 32];
            e.pay = 640'({mem_cmd, model[idx(a)]});
        end
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (wr) mem_data_cmd_v = 1'b0;
        else mem_cmd_v = 1'b0;
    endtask

    // Wait for a response, compare it, optionally stall, then consume it.
    task automatic get_resp(input int hold, input int exp_lat);
        exp_t         e;
        int           n = 0;
        logic [639:0] got;
        while (!(mem_resp_v || mem_data_resp_v) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("resp_valid", mem_resp_v | mem_data_resp_v, 1);
        if (!(mem_resp_v || mem_data_resp_v)) return;
        chk("sb_nonempty", sbq.size() > 0, 1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        if (exp_lat >= 0) chk("latency", n, exp_lat);
        chk("channel", {mem_resp_v, mem_data_resp_v}, e.wr ? 2'b10 : 2'b01);
        got = e.wr ? 640'(mem_resp) : 640'(mem_data_resp);
        chk(e.wr ? "wr_ack" : "rd_data", got, e.pay);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            got = e.wr ? 640'(mem_resp) : 640'(mem_data_resp);
            chk("hold_payload", got, e.pay);
            chk("hold_valid", e.wr ? mem_resp_v : mem_data_resp_v, 1);
            chk("hold_ready", {mem_cmd_ready, mem_data_cmd_ready}, 0);
        end
        if (e.wr) mem_resp_yumi = 1'b1;
        else mem_data_resp_yumi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_resp_yumi      = 1'b0;
        mem_data_resp_yumi = 1'b0;
        chk("valid_drop", {mem_resp_v, mem_data_resp_v}, 2'b00);
        chk("ready_after", {mem_cmd_ready, mem_data_cmd_ready}, 2'b11);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", {mem_cmd_ready, mem_data_cmd_ready}, 2'b00);
        end
        chk("rst_valid", {mem_resp_v, mem_data_resp_v}, 2'b00);
        chk("rst_resp", 640'(mem_resp), 0);
        chk("rst_data_resp", 640'(mem_data_resp), 0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", {mem_cmd_ready, mem_data_cmd_ready}, 2'b11);

        set_rd(32'h40, 1'b0, 3'd0, 1'b0);
        acc(0);
        get_resp(0, LAT);

        // Writeback then read.
        set_wr(32'h1000, {64{8'hA5}}, 1'b0, 3'd5);
        acc(1);
        get_resp(0, LAT);
        set_rd(32'h1000, 1'b1, 3'd3, 1'b0);
        acc(0);
        get_resp(0, LAT);

        // Simultaneous writeback and read to the same block.
        set_wr(32'h2000, {32{16'h5A3C}}, 1'b1, 3'd1);
        set_rd(32'h2000, 1'b0, 3'd2, 1'b0);
        #1;
        chk("both_v_cmd_ready", mem_cmd_ready, 0);
        chk("both_v_dc_ready", mem_data_cmd_ready, 1);
        acc(1);
        get_resp(0, LAT);
        acc(0);
        get_resp(0, LAT);

        // Backpressure on read data.
        set_wr(32'h80, {16{32'hDEADBEEF}}, 1'b0, 3'd7);
        acc(1);
        get_resp(0, LAT);
        set_rd(32'h80, 1'b1, 3'd2, 1'b0);
        acc(0);
        get_resp(10, LAT);

        // Aliasing: 0x440 maps onto the same block as 0x40.
        set_wr(32'h40, {8{64'h0123456789ABCDEF}}, 1'b1, 3'd4);
        acc(1);
        get_resp(0, LAT);
        set_rd(32'h440, 1'b0, 3'd6, 1'b1);
        acc(0);
        get_resp(0, LAT);

        // Reset while a read is waiting.
        set_rd(32'h1000, 1'b1, 3'd1, 1'b0);
        acc(0);
        watch = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        void'(sbq.pop_back());
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        chk("midrst_ready", {mem_cmd_ready, mem_data_cmd_ready}, 2'b00);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        watch = 1'b0;
        chk("midrst_no_resp", pulses, 0);
        chk("midrst_sb_empty", sbq.size(), 0);
        set_rd(32'h1000, 1'b0, 3'd0, 1'b0);
        acc(0);
        get_resp(0, LAT);
        set_rd(32'h40, 1'b1, 3'd3, 1'b0);
        acc(0);
        get_resp(0, LAT);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
